// File: rtl/dcache_controller_if.sv
// Block-wide main-memory port of the data cache.
// master = cache side, slave = memory side.
interface dcache_controller_if;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic         mem_read_en;
  logic         mem_write_en;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport master (
    output mem_address,
    output mem_writedata,
    output mem_read_en,
    output mem_write_en,
    input  mem_readdata,
    input  mem_busywait
  );

  modport slave (
    input  mem_address,
    input  mem_writedata,
    input  mem_read_en,
    input  mem_write_en,
    output mem_readdata,
    output mem_busywait
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache
// between the MA stage and a 128-bit block memory.
module dcache_controller #(
  parameter int NUM_LINES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  output logic [31:0] readdata,
  output logic        busywait,
  dcache_controller_if.master mem
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 28 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];
  logic [127:0]         fill_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   atag;
  logic               rd_req;
  logic               wr_req;
  logic               req;
  logic               hit;
  logic               store_hit;

  assign idx    = address[4 +: INDEX_W];
  assign atag   = address[31 -: TAG_W];
  assign wr_req = mem_write[2];
  assign rd_req = mem_read[3] & ~wr_req;
  assign req    = mem_read[3] | wr_req;
  assign hit    = valid_q[idx] &&
                  (tag_q[idx] == atag);
  assign store_hit = (state_q == IDLE) &&
                     wr_req && hit;

  always_comb begin
    state_d           = state_q;
    busywait          = 1'b0;
    mem.mem_read_en   = 1'b0;
    mem.mem_write_en  = 1'b0;
    mem.mem_address   = '0;
    mem.mem_writedata = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          busywait = req & ~hit;
          if (req && !hit)
            state_d = dirty_q[idx] ?
                      WRITEBACK : FETCH;
        end
        WRITEBACK: begin
          busywait          = 1'b1;
          mem.mem_write_en  = 1'b1;
          mem.mem_address   = {tag_q[idx], idx};
          mem.mem_writedata = data_q[idx];
          if (!mem.mem_busywait)
            state_d = FETCH;
        end
        FETCH: begin
          busywait        = 1'b1;
          mem.mem_read_en = 1'b1;
          mem.mem_address = address[31:4];
          if (!mem.mem_busywait)
            state_d = UPDATE;
        end
        UPDATE: begin
          busywait = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == UPDATE) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Store merge: lane shift selected by access size.
  logic [6:0]   wsh;
  logic [127:0] wmask;
  logic [127:0] wbits;

  always_comb begin
    wsh   = '0;
    wmask = '0;
    wbits = '0;
    unique case (1'b1)
      (mem_write[1:0] == 2'b00): begin
        wsh   = {address[3:0], 3'b000};
        wmask = 128'hFF << wsh;
        wbits = {120'b0, writedata[7:0]} << wsh;
      end
      (mem_write[1:0] == 2'b01): begin
        wsh   = {address[3:1], 4'b0000};
        wmask = 128'hFFFF << wsh;
        wbits = {112'b0, writedata[15:0]} << wsh;
      end
      default: begin
        wsh   = {address[3:2], 5'b00000};
        wmask = 128'hFFFF_FFFF << wsh;
        wbits = {96'b0, writedata} << wsh;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == FETCH && !mem.mem_busywait)
        fill_q <= mem.mem_readdata;
      if (state_q == UPDATE) begin
        data_q[idx] <= fill_q;
        tag_q[idx]  <= atag;
      end else if (store_hit) begin
        data_q[idx] <= (data_q[idx] & ~wmask) |
                       (wbits & wmask);
      end
    end
  end

  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] rext;

  assign rword = data_q[idx][{address[3:2], 5'b0} +: 32];
  assign rbyte = rword[{address[1:0], 3'b0} +: 8];
  assign rhalf = rword[{address[1], 4'b0} +: 16];

  always_comb begin
    rext = rword;
    unique case (1'b1)
      (mem_read[2:0] == 3'b000):
        rext = {{24{rbyte[7]}}, rbyte};
      (mem_read[2:0] == 3'b001):
        rext = {{16{rhalf[15]}}, rhalf};
      (mem_read[2:0] == 3'b100):
        rext = {24'b0, rbyte};
      (mem_read[2:0] == 3'b101):
        rext = {16'b0, rhalf};
      default:
        rext = rword;
    endcase
  end

  assign readdata = (!rst && state_q == IDLE &&
                     rd_req && hit) ? rext : '0;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a
// latency-5 block memory model.
module tb_dcache_controller;
  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] writedata = '0;
  logic [3:0]  mem_read = '0;
  logic [2:0]  mem_write = '0;
  logic [31:0] readdata;
  logic        busywait;

  dcache_controller_if bus ();

  dcache_controller #(.NUM_LINES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .writedata (writedata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .readdata  (readdata),
    .busywait  (busywait),
    .mem       (bus.master)
  );

  always #5 clk = ~clk;

  logic [127:0] mem_arr [256];
  int           mem_cnt;
  logic         mreq;

  assign mreq = bus.mem_read_en | bus.mem_write_en;
  assign bus.mem_busywait = mreq && (mem_cnt != LAT);
  assign bus.mem_readdata = mem_arr[bus.mem_address[7:0]];

  initial begin
    for (int i = 0; i < 256; i++)
      for (int w = 0; w < 4; w++)
        mem_arr[i][32*w +: 32] =
          32'hA000_0000 | 32'(i * 16 + w * 4);
    mem_cnt = 0;
    forever begin
      @(posedge clk);
      if (bus.mem_write_en && !bus.mem_busywait)
        mem_arr[bus.mem_address[7:0]] <= bus.mem_writedata;
      if (!mreq || !bus.mem_busywait)
        mem_cnt <= 0;
      else
        mem_cnt <= mem_cnt + 1;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busywait && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic do_store(input string tag,
                          input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [1:0] f);
    int n;
    address   = a;
    writedata = d;
    mem_read  = 4'b0;
    mem_write = {1'b1, f};
    #1;
    wait_ready(n);
    check(tag, 32'(n < 100), 32'd1);
    tick();
    mem_write = 3'b0;
  endtask

  task automatic do_load(input string tag,
                         input logic [31:0] a,
                         input logic [2:0] f,
                         input logic [31:0] exp);
    int n;
    address   = a;
    mem_write = 3'b0;
    mem_read  = {1'b1, f};
    #1;
    wait_ready(n);
    check({tag, "_to"}, 32'(n < 100), 32'd1);
    check(tag, readdata, exp);
  endtask

  int n;
  int traffic;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busywait), 0);
    check("rst_rdata", readdata, 0);
    check("rst_rden", 32'(bus.mem_read_en), 0);
    check("rst_wren", 32'(bus.mem_write_en), 0);
    check("rst_maddr", 32'(bus.mem_address), 0);
    check("rst_mwd", bus.mem_writedata[31:0], 0);

    // 1: cold read miss
    address  = 32'h40;
    mem_read = 4'b1010;
    #1;
    check("t1_busy", 32'(busywait), 1);
    tick();
    check("t1_rden", 32'(bus.mem_read_en), 1);
    check("t1_wren", 32'(bus.mem_write_en), 0);
    check("t1_maddr", 32'(bus.mem_address), 32'h4);
    wait_ready(n);
    check("t1_stall", n + 1, 8);
    check("t1_rdata", readdata, 32'hA000_0040);

    // 2: write hit, no stall
    mem_read  = 4'b0;
    mem_write = 3'b110;
    address   = 32'h44;
    writedata = 32'hDEAD_BEEF;
    #1;
    check("t2_nostall", 32'(busywait), 0);
    tick();
    do_load("t2_rd", 32'h44, 3'b010, 32'hDEAD_BEEF);
    check("t2_busy", 32'(busywait), 0);

    // 3: dirty victim writeback then fetch
    address = 32'hC4;
    #1;
    check("t3_busy", 32'(busywait), 1);
    tick();
    check("t3_wren", 32'(bus.mem_write_en), 1);
    check("t3_rden", 32'(bus.mem_read_en), 0);
    check("t3_wbaddr", 32'(bus.mem_address), 32'h4);
    check("t3_wbdata", bus.mem_writedata[63:32],
          32'hDEAD_BEEF);
    n = 1;
    while (bus.mem_write_en && n < 100) begin
      tick();
      n++;
    end
    check("t3_fren", 32'(bus.mem_read_en), 1);
    check("t3_faddr", 32'(bus.mem_address), 32'hC);
    begin
      int m;
      wait_ready(m);
      check("t3_stall", n + m, 14);
    end
    check("t3_rdata", readdata, 32'hA000_00C4);

    // 4: sub-word stores and extension
    do_store("t4_sb", 32'h45, 32'h1234_5680, 2'b00);
    do_load("t4_lb", 32'h45, 3'b000, 32'hFFFF_FF80);
    do_load("t4_lbu", 32'h45, 3'b100, 32'h0000_0080);
    do_load("t4_lw", 32'h44, 3'b010, 32'hDEAD_80EF);
    do_store("t4_sh", 32'h46, 32'hABCD_8001, 2'b01);
    do_load("t4_lh", 32'h46, 3'b001, 32'hFFFF_8001);
    do_load("t4_lhu", 32'h46, 3'b101, 32'h0000_8001);
    do_load("t4_lw2", 32'h44, 3'b010, 32'h8001_80EF);

    // 5: reset aborts a fetch
    address  = 32'h50;
    mem_read = 4'b1010;
    #1;
    tick();
    check("t5_rden", 32'(bus.mem_read_en), 1);
    tick();
    tick();
    rst      = 1'b1;
    mem_read = 4'b0;
    tick();
    rst = 1'b0;
    #1;
    check("t5_busy", 32'(busywait), 0);
    check("t5_rden0", 32'(bus.mem_read_en), 0);
    check("t5_maddr", 32'(bus.mem_address), 0);
    tick();
    check("t5_rden1", 32'(bus.mem_read_en), 0);
    address  = 32'h40;
    mem_read = 4'b1010;
    #1;
    check("t5_miss", 32'(busywait), 1);
    tick();
    check("t5_nowb", 32'(bus.mem_write_en), 0);
    check("t5_fetch", 32'(bus.mem_read_en), 1);
    wait_ready(n);
    check("t5_stall", n + 1, 8);
    check("t5_rdata", readdata, 32'hA000_0040);
    do_load("t5_disc", 32'h44, 3'b010, 32'hDEAD_BEEF);

    // 6: read+write together, write wins
    address   = 32'h48;
    writedata = 32'h5A5A_5A5A;
    mem_read  = 4'b1010;
    mem_write = 3'b110;
    #1;
    check("t6_nostall", 32'(busywait), 0);
    tick();
    do_load("t6_rd", 32'h48, 3'b010, 32'h5A5A_5A5A);
    address = 32'hC8;
    #1;
    tick();
    check("t6_wren", 32'(bus.mem_write_en), 1);
    check("t6_wbdata", bus.mem_writedata[95:64],
          32'h5A5A_5A5A);
    wait_ready(n);
    check("t6_to", 32'(n < 100), 1);
    check("t6_rdata", readdata, 32'hA000_00C8);

    mem_read  = 4'b0;
    mem_write = 3'b0;
    traffic   = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busywait || bus.mem_read_en ||
          bus.mem_write_en)
        traffic++;
    end
    check("t6_idle", 32'(traffic), 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate data cache between the CPU memory-access stage and the block-wide data memory. It consumes the MA-stage signals DMEM_ADDR_MA, DMEM_DATA_WRITE_MA, DMEM_READ_MA and DMEM_WRITE_MA, and returns DMEM_DATA_READ_MA and the BUSYWAIT that stalls pc and all pipeline registers. On a miss it runs a writeback/fetch sequence against a 128-bit main-memory port.

Parameters:
NUM_LINES, 8, number of cache lines; power of 2, minimum 2. INDEX_W = log2(NUM_LINES).
BLOCK_BYTES, 16, fixed at four 32-bit words. Offset = addr[3:0]. TAG_W = 28 - INDEX_W.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
address  in  32  byte address from MA stage
writedata  in  32  store data; the low byte/half is used for SB/SH
mem_read  in  4  [3]=enable, [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
mem_write  in  3  [2]=enable, [1:0]=funct3[1:0] (00 SB, 01 SH, 10 SW)
readdata  out  32  load result, sign- or zero-extended per funct3
busywait  out  1  stall request to the pipeline
mem_address  out  28  block address to main memory ({tag,index})
mem_writedata  out  128  victim block
mem_read_en  out  1  main-memory block read request
mem_write_en  out  1  main-memory block write request
mem_readdata  in  128  fetched block
mem_busywait  in  1  main memory busy; the transfer completes on the first cycle it is low while a request is held

Behaviour:
- Arrays: valid[NUM_LINES], dirty[NUM_LINES], tag[NUM_LINES], data[NUM_LINES] of 128 bits. Word w sits at bits [32w+31:32w], w = addr[3:2].
- Request = mem_read[3] | mem_write[2]. If both are set, the write wins and readdata is don't-care.
- hit = valid[index] & (tag[index] == address[31:4+INDEX_W]). Computed combinationally.
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE:
  - busywait = request & ~hit.
  - Read hit: readdata is valid combinationally in the same cycle, zero added latency.
  - Write hit: merge the byte/half/word at the clock edge and set dirty.
  - Miss with a dirty victim: go to WRITEBACK. Miss with a clean or invalid line: go to FETCH.
- WRITEBACK:
  - Drive mem_write_en=1, mem_address={tag[index],index}, mem_writedata=data[index].
  - When mem_busywait=0: go to FETCH.
- FETCH:
  - Drive mem_read_en=1, mem_address=address[31:4].
  - When mem_busywait=0: capture mem_readdata and go to UPDATE.
- UPDATE (one cycle):
  - Write the block, tag[index]=new tag, valid=1, dirty=0. Return to IDLE.
  - The next cycle hits, and a pending store merges then.
- busywait=1 in WRITEBACK, FETCH and UPDATE. A miss costs writeback + fetch + 2 cycles beyond memory latency.
- mem_read_en and mem_write_en are never both 1. Both are 0 in IDLE and UPDATE.
- Alignment:
  - Halfword uses addr[1] and ignores addr[0].
  - Word ignores addr[1:0].
  - Byte uses addr[1:0].
  - Misaligned traps are not supported.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. Unknown funct3 returns the full word.
- Reset:
  - State goes to IDLE. All valid and dirty bits clear; tags and data are left unchanged.
  - Outputs go to busywait=0, readdata=0, mem_read_en=0, mem_write_en=0, mem_address=0, mem_writedata=0.
  - Reset in any state aborts the transaction immediately. The dirty victim is discarded; no memory request is issued in the following cycle.
- The address and request must be held stable by the stalled pipeline while busywait=1. Behaviour is undefined if they change.
- No request: busywait=0 and the arrays are unchanged.

Test Plan:
1. Reset, then LW 0x0000_0040, memory latency 5 -> busywait high, FETCH with mem_address=0x0000004, then UPDATE. The next cycle hits: readdata equals word 0 of the fetched block and busywait is low.
2. SW 0xDEADBEEF to 0x44 after test 1, then LW 0x44 -> write hit with no stall; the line becomes dirty and readdata=0xDEADBEEF the next cycle with busywait=0.
3. With 0x44 dirty, LW 0x0000_00C4 (same index 4, different tag) -> WRITEBACK with mem_address=0x0000004 and mem_writedata[63:32]=0xDEADBEEF, then FETCH with mem_address=0x000000C.
4. Store byte 0x80 to 0x45, then LB and LBU from 0x45 -> 0xFFFFFF80 and 0x00000080. SH 0x8001 to 0x46, then LH 0x46 -> 0xFFFF8001.
5. rst asserted during FETCH with mem_busywait still high -> next cycle: state IDLE, mem_read_en=0, busywait=0, and all lines invalid. A re-access of 0x40 misses again.
6. mem_read and mem_write both enabled on a hit -> the write commits and the dirty bit sets. Idle cycles with no request -> busywait=0 and no memory traffic.
